// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM state encoding,
// requester IDs and the default bus widths also used by the control matrix.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_F = 2'd1,
      GNT_D = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      REQ_F = 1'b0,
      REQ_D = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_arb_rr_pick.sv
// Two-way round-robin picker: on a conflict the requester that was not
// granted last wins; a lone requester always wins.
module arb_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic    f_req,
   input  logic    d_req,
   input  req_id_e last_gnt,
   output logic    gnt_f,
   output logic    gnt_d
);

   assign gnt_f = f_req && (!d_req || (last_gnt == REQ_D));
   assign gnt_d = d_req && (!f_req || (last_gnt == REQ_F));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto the single byte-wide memory port,
// one outstanding transaction at a time. Define ARB_TIMEOUT_EN to bound the
// wait for mem_ack to TIMEOUT cycles and raise a sticky err flag on expiry.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_done,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   arb_state_e        state_q, state_d;
   req_id_e           last_gnt_q, last_gnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              f_done_q, f_done_d;
   logic              d_done_q, d_done_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              gnt_f, gnt_d;
   logic              in_gnt;
   logic              tmo;

   arb_rr_pick u_pick (
      .f_req    (f_req),
      .d_req    (d_req),
      .last_gnt (last_gnt_q),
      .gnt_f    (gnt_f),
      .gnt_d    (gnt_d)
   );

   assign in_gnt = (state_q == GNT_F) || (state_q == GNT_D);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Counter holds the number of ack-less wait cycles already spent in GNT_x.
   always_comb begin
      cnt_d = '0;
      tmo   = 1'b0;
      err_d = err_q;
      if (in_gnt && !mem_ack) begin
         if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            tmo   = 1'b1;
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      f_done_d    = 1'b0;
      d_done_d    = 1'b0;
      f_rdata_d   = f_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_f) begin
               state_d     = GNT_F;
               last_gnt_d  = REQ_F;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = f_addr;
               mem_wdata_d = '0;
            end else if (gnt_d) begin
               state_d     = GNT_D;
               last_gnt_d  = REQ_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end
         end
         GNT_F, GNT_D: begin
            // An ack on the expiry cycle still counts as a normal completion.
            if (mem_ack || tmo) begin
               if (mem_ack && !mem_we_q) begin
                  if (state_q == GNT_F) f_rdata_d = mem_rdata;
                  else                  d_rdata_d = mem_rdata;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               f_done_d  = (state_q == GNT_F);
               d_done_d  = (state_q == GNT_D);
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         last_gnt_q  <= REQ_F;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         f_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         f_done_q    <= f_done_d;
         d_done_q    <= d_done_d;
         f_rdata_q   <= f_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign f_done    = f_done_q;
   assign d_done    = d_done_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// checked every cycle; ARB_TIMEOUT_EN selects the timeout scenarios.
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              f_req = 1'b0;
   logic [ADDR_W-1:0] f_addr = '0;
   logic              f_done;
   logic [DATA_W-1:0] f_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              err;

   int n_chk = 0;
   int n_err = 0;
   int n_fdone = 0;
   int n_ddone = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
   );

   // Reference model: owner 0 = none, 1 = fetch, 2 = data; cool marks the dead cycle.
   int                m_busy = 0;
   int                m_wait = 0;
   bit                m_cool = 1'b0;
   bit                m_last_d = 1'b0;
   bit                m_we = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   bit                m_f_done = 1'b0;
   bit                m_d_done = 1'b0;
   logic [DATA_W-1:0] m_f_rdata = '0;
   logic [DATA_W-1:0] m_d_rdata = '0;
   bit                m_err = 1'b0;
   logic              take_d;

   assign take_d = d_req && (!f_req || !m_last_d);

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 0; m_wait <= 0; m_cool <= 1'b0; m_last_d <= 1'b0;
         m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
         m_f_done <= 1'b0; m_d_done <= 1'b0;
         m_f_rdata <= '0; m_d_rdata <= '0; m_err <= 1'b0;
      end else begin
         m_f_done <= 1'b0;
         m_d_done <= 1'b0;
         if (m_busy != 0) begin
            if (mem_ack || (TO_EN && (m_wait + 1 == TIMEOUT))) begin
               if (mem_ack && !m_we) begin
                  if (m_busy == 1) m_f_rdata <= mem_rdata;
                  else             m_d_rdata <= mem_rdata;
               end
               if (!mem_ack) m_err <= 1'b1;
               if (m_busy == 1) m_f_done <= 1'b1;
               else             m_d_done <= 1'b1;
               m_busy <= 0;
               m_cool <= 1'b1;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (m_cool) begin
            m_cool <= 1'b0;
         end else if (f_req || d_req) begin
            m_busy   <= take_d ? 2 : 1;
            m_last_d <= take_d;
            m_we     <= take_d && d_we;
            m_addr   <= take_d ? d_addr : f_addr;
            m_wdata  <= d_wdata;
            m_wait   <= 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      chk("mem_req", 32'(mem_req), 32'(m_busy != 0));
      chk("f_done", 32'(f_done), 32'(m_f_done));
      chk("d_done", 32'(d_done), 32'(m_d_done));
      chk("f_rdata", 32'(f_rdata), 32'(m_f_rdata));
      chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
      chk("err", 32'(err), 32'(m_err));
      if (m_busy != 0) begin
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("mem_we", 32'(mem_we), 32'(m_we));
         if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      if (f_done) n_fdone++;
      if (d_done) n_ddone++;
   endtask

   // Compare on the falling edge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clock);
      cmp_all();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_mem_req();
      int k;
      k = 0;
      tick();
      while (!mem_req && k < 8) begin
         tick();
         k++;
      end
      chk("wait_mem_req", 32'(mem_req), 32'd1);
   endtask

   task automatic run_txn(input bit is_d, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                          input int dly, output int we_cyc);
      we_cyc = 0;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      end else begin
         f_req = 1'b1; f_addr = addr;
      end
      wait_mem_req();
      chk("txn_addr", 32'(mem_addr), 32'(addr));
      chk("txn_we", 32'(mem_we), 32'(we));
      for (int j = 0; j < dly; j++) begin
         if (mem_req && mem_we && mem_wdata == wd) we_cyc++;
         if (j == dly - 1) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
         end
         tick();
      end
      mem_ack = 1'b0;
      mem_rdata = '0;
      chk("txn_done", 32'(is_d ? d_done : f_done), 32'd1);
      chk("txn_other_done", 32'(is_d ? f_done : d_done), 32'd0);
      chk("txn_req_drop", 32'(mem_req), 32'd0);
      if (is_d) d_req = 1'b0;
      else      f_req = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wec;
      int nd;
      int ngr;
      int ndn;
      int hc;
      bit prev;
      bit gr[4];
      int dn[4];
      logic [DATA_W-1:0] saved;

      reset_n = 1'b0;
      tick(); tick(); tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_f_rdata", 32'(f_rdata), 32'd0);
      chk("rst_d_rdata", 32'(d_rdata), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset_n = 1'b1;
      tick();

      // Fetch read, ack one cycle after mem_req.
      run_txn(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1, wec);
      chk("t1_f_rdata", 32'(f_rdata), 32'hA5);
      chk("t1_f_done_cnt", 32'(n_fdone), 32'd1);
      chk("t1_d_done_cnt", 32'(n_ddone), 32'd0);

      // Data write, ack after 5 cycles.
      run_txn(1'b1, 1'b1, 16'h8000, 8'h3C, 8'hEE, 5, wec);
      chk("t2_we_cycles", 32'(wec), 32'd5);
      chk("t2_d_rdata", 32'(d_rdata), 32'h00);
      chk("t2_d_done_cnt", 32'(n_ddone), 32'd1);

      // Reset asserted mid data transaction.
      nd = n_ddone;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
      wait_mem_req();
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t4_async_mem_req", 32'(mem_req), 32'd0);
      chk("t4_async_d_done", 32'(d_done), 32'd0);
      d_req = 1'b0;
      tick();
      reset_n = 1'b1;
      tick(); tick();
      chk("t4_no_d_done", 32'(n_ddone), 32'(nd));
      run_txn(1'b0, 1'b0, 16'h0123, 8'h00, 8'h5A, 2, wec);
      chk("t4_f_rdata", 32'(f_rdata), 32'h5A);

      // Continuous conflict: grants alternate D, F, D, F.
      f_addr = 16'h1000; d_addr = 16'h2000; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      ngr = 0; ndn = 0; prev = 1'b0;
      for (int i = 0; i < 40 && ndn < 4; i++) begin
         tick();
         if (mem_req && !prev && ngr < 4) begin
            gr[ngr] = (mem_addr == 16'h2000);
            ngr++;
         end
         prev = mem_req;
         if ((f_done || d_done) && ndn < 4) begin
            dn[ndn] = i;
            ndn++;
         end
         mem_ack = mem_req;
         mem_rdata = 8'(i + 64);
         if (ndn == 4) begin
            f_req = 1'b0;
            d_req = 1'b0;
         end
      end
      mem_ack = 1'b0;
      mem_rdata = '0;
      chk("t3_grants", 32'(ngr), 32'd4);
      chk("t3_dones", 32'(ndn), 32'd4);
      chk("t3_g0_is_d", 32'(gr[0]), 32'd1);
      chk("t3_g1_is_d", 32'(gr[1]), 32'd0);
      chk("t3_g2_is_d", 32'(gr[2]), 32'd1);
      chk("t3_g3_is_d", 32'(gr[3]), 32'd0);
      for (int k = 1; k < 4; k++) chk("t3_done_gap", 32'(dn[k] - dn[k-1]), 32'd3);
      tick(); tick();

`ifdef ARB_TIMEOUT_EN
      // No ack at all: expiry after TIMEOUT cycles, err sticks.
      saved = f_rdata;
      f_req = 1'b1; f_addr = 16'h0AAA;
      wait_mem_req();
      hc = 0;
      while (mem_req && hc < 40) begin
         hc++;
         tick();
      end
      chk("t5_req_cycles", 32'(hc), 32'd15);
      chk("t5_f_done", 32'(f_done), 32'd1);
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_f_rdata_kept", 32'(f_rdata), 32'(saved));
      f_req = 1'b0;
      tick(); tick();
      run_txn(1'b1, 1'b0, 16'h0200, 8'h00, 8'h31, 3, wec);
      chk("t5_err_sticky", 32'(err), 32'd1);
      chk("t5_d_rdata", 32'(d_rdata), 32'h31);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      // Ack on the final wait cycle wins over the timeout.
      run_txn(1'b0, 1'b0, 16'h0300, 8'h00, 8'h77, 15, wec);
      chk("t6_f_rdata", 32'(f_rdata), 32'h77);
      chk("t6_err", 32'(err), 32'd0);
`else
      // Without the timeout feature the grant waits indefinitely.
      saved = f_rdata;
      f_req = 1'b1; f_addr = 16'h0FFF;
      wait_mem_req();
      hc = 0;
      while (mem_req && hc < 20) begin
         hc++;
         tick();
      end
      chk("t5_still_waiting", 32'(mem_req), 32'd1);
      chk("t5_wait_cycles", 32'(hc), 32'd20);
      chk("t5_f_rdata_kept", 32'(f_rdata), 32'(saved));
      chk("t5_err", 32'(err), 32'd0);
      mem_ack = 1'b1; mem_rdata = 8'h99;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("t5_f_done", 32'(f_done), 32'd1);
      f_req = 1'b0;
      tick(); tick();
      chk("t5_f_rdata", 32'(f_rdata), 32'h99);
`endif

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
